// File: rtl/key_schedule_mem_pkg.sv
// Shared AES-128 key-expansion constants, FSM encodings and the GF(2^8) doubling helper.
package key_schedule_mem_pkg;

  localparam int ROUNDS = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GEN  = 1'b1;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  typedef logic [127:0] block_t;
  typedef logic [31:0]  word_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] shifted;
    shifted = {b[6:0], 1'b0};
    return b[7] ? (shifted ^ XTIME_POLY) : shifted;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion round: builds the next four words from the previous
// round key and the S-box output of its last word.
module aes_key_step
  import key_schedule_mem_pkg::*;
(
  input  logic [127:0] prevKey,
  input  logic [31:0]  afterSub,
  input  logic [7:0]   rcon,
  output logic [127:0] next
);

  word_t t;
  word_t n0, n1, n2, n3;

  // RotWord is applied after SubWord; the byte permutation commutes with the S-box.
  assign t  = {afterSub[23:0], afterSub[31:24]} ^ {rcon, 24'h0};
  assign n0 = prevKey[127:96] ^ t;
  assign n1 = prevKey[95:64]  ^ n0;
  assign n2 = prevKey[63:32]  ^ n1;
  assign n3 = prevKey[31:0]   ^ n2;

  assign next = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_mem.sv
// AES-128 round-key generator and store; expands one round key per cycle using a
// shared external S-box, then serves round keys by index.
//
// state    | meaning
// ST_IDLE  | schedule stable (or empty); waits for init, S-box not used
// ST_GEN   | writes KM[ctr] each cycle, ctr = 1..NUM_ROUNDS
module key_schedule_mem
  import key_schedule_mem_pkg::*;
#(
  parameter int NUM_ROUNDS = ROUNDS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic [127:0] key,
  input  logic [3:0]   round,
  output logic [127:0] roundKey,
  output logic [31:0]  beforeSub,
  input  logic [31:0]  afterSub,
  output logic         ready,
  output logic         keyValid
);

  logic [0:0]   state;
  logic [3:0]   ctr;
  logic [7:0]   rcon;
  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [127:0] km [0:NUM_ROUNDS];

  aes_key_step u_step (
    .prevKey  (prev_key),
    .afterSub (afterSub),
    .rcon     (rcon),
    .next     (next_key)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      keyValid <= 1'b0;
      ctr      <= 4'd0;
      rcon     <= RCON_INIT;
      prev_key <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) km[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (init) begin
            km[0]    <= key;
            prev_key <= key;
            ctr      <= 4'd1;
            rcon     <= RCON_INIT;
            keyValid <= 1'b0;
            state    <= ST_GEN;
          end
        end
        ST_GEN: begin
          for (int i = 1; i <= NUM_ROUNDS; i++) begin
            if (ctr == 4'(i)) km[i] <= next_key;
          end
          prev_key <= next_key;
          ctr      <= ctr + 4'd1;
          rcon     <= xtime(rcon);
          if (ctr == 4'(NUM_ROUNDS)) begin
            keyValid <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready     = (state == ST_IDLE);
  assign beforeSub = (state == ST_GEN) ? prev_key[31:0] : 32'h0;

  // Indices above the last round read as zero rather than aliasing a stored key.
  always_comb begin
    roundKey = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (round == 4'(i)) roundKey = km[i];
    end
  end

endmodule

// File: tb/tb_key_schedule_mem.sv
// Scoreboard bench for key_schedule_mem: stimulus queues expected schedules,
// a monitor checks each one when the block returns to ready.
module tb_key_schedule_mem;

  typedef struct {
    logic [127:0] km0;
    logic [127:0] km1;
    logic [127:0] km10;
    logic         valid;
    int           lat;
  } exp_t;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_KM1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_KM10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_KM1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_KM10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk;
  logic         reset;
  logic         init;
  logic [127:0] key;
  logic [3:0]   round;
  logic [127:0] roundKey;
  logic [31:0]  beforeSub;
  logic [31:0]  afterSub;
  logic         ready;
  logic         keyValid;

  int   vectors    = 0;
  int   miscompares = 0;
  int   done_cnt   = 0;
  exp_t exp_q[$];

  key_schedule_mem #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .key       (key),
    .round     (round),
    .roundKey  (roundKey),
    .beforeSub (beforeSub),
    .afterSub  (afterSub),
    .ready     (ready),
    .keyValid  (keyValid)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reference S-box: multiplicative inverse in GF(2^8) followed by the affine map.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv, sq, s;
    inv = 8'h01; sq = b;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    if (b == 8'h00) inv = 8'h00;
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  always_comb begin
    afterSub = {sbox(beforeSub[31:24]), sbox(beforeSub[23:16]),
                sbox(beforeSub[15:8]), sbox(beforeSub[7:0])};
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_check(input string name, input logic [3:0] idx, input logic [127:0] exp);
    round = idx;
    #1;
    check(name, roundKey, exp);
  endtask

  // Monitor: a rising ready marks a finished (or aborted) expansion.
  initial begin
    logic rdy, prev_ready;
    int   busy;
    exp_t e;
    round      = 4'd0;
    prev_ready = 1'b1;
    busy       = 0;
    forever begin
      @(negedge clk);
      rdy = ready;
      if (!rdy) begin
        busy++;
      end else if (!prev_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_completion: got ready rise expected none");
        end else begin
          e = exp_q.pop_front();
          check("keyValid_at_done", 128'(keyValid), 128'(e.valid));
          if (e.lat >= 0) check("latency", 128'(busy), 128'(e.lat));
          read_check("rk0",  4'd0,  e.km0);
          read_check("rk1",  4'd1,  e.km1);
          read_check("rk10", 4'd10, e.km10);
          read_check("rk11", 4'd11, 128'h0);
          read_check("rk15", 4'd15, 128'h0);
          round = 4'd0;
        end
        busy = 0;
        done_cnt++;
      end
      prev_ready = rdy;
    end
  end

  task automatic accept(input logic [127:0] k, input exp_t e);
    @(negedge clk);
    key  = k;
    init = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    check("ready_after_accept", 128'(ready), 128'(1'b0));
    check("keyValid_after_accept", 128'(keyValid), 128'(1'b0));
    check("beforeSub_first_gen", 128'(beforeSub), 128'(k[31:0]));
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 40 && done_cnt < target; i++) @(negedge clk);
    vectors++;
    if (done_cnt < target) begin
      miscompares++;
      $display("FAIL wait_done: got %0d completions expected %0d", done_cnt, target);
    end
  endtask

  initial begin
    exp_t fips_e, zero_e, abort_e;
    fips_e  = '{km0: FIPS_KEY, km1: FIPS_KM1, km10: FIPS_KM10, valid: 1'b1, lat: 10};
    zero_e  = '{km0: 128'h0,   km1: ZERO_KM1, km10: ZERO_KM10, valid: 1'b1, lat: 10};
    abort_e = '{km0: 128'h0,   km1: 128'h0,   km10: 128'h0,    valid: 1'b0, lat: -1};

    reset = 1'b0;
    init  = 1'b0;
    key   = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 128'(ready), 128'(1'b1));
    check("reset_keyValid", 128'(keyValid), 128'(1'b0));
    check("reset_beforeSub", 128'(beforeSub), 128'h0);
    check("reset_rk0", roundKey, 128'h0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_beforeSub", 128'(beforeSub), 128'h0);

    // FIPS-197 key, then the all-zero key straight after completion.
    accept(FIPS_KEY, fips_e);
    wait_done(1);
    accept(128'h0, zero_e);
    wait_done(2);

    // A second init and a key change mid-expansion must be ignored.
    accept(FIPS_KEY, fips_e);
    repeat (2) @(negedge clk);
    key  = 128'h0;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check("ready_low_mid_gen", 128'(ready), 128'(1'b0));
    wait_done(3);

    // Reset at E+5 discards the schedule; init on the first released edge is taken.
    accept(FIPS_KEY, fips_e);
    void'(exp_q.pop_back());
    repeat (4) @(negedge clk);
    exp_q.push_back(abort_e);
    reset = 1'b0;
    @(negedge clk);
    check("abort_beforeSub", 128'(beforeSub), 128'h0);
    check("abort_keyValid", 128'(keyValid), 128'(1'b0));
    reset = 1'b1;
    key   = 128'h0;
    init  = 1'b1;
    exp_q.push_back(zero_e);
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    check("ready_after_release_init", 128'(ready), 128'(1'b0));
    wait_done(5);

    check("queue_drained", 128'(exp_q.size()), 128'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
